multicycle_seq_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I core datapath. Steps each instruction through

---
 rtl/core_ctrl_pkg.sv | 63 ++++++
 rtl/seq_watchdog.sv | 32 +++
 rtl/multicycle_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: opcodes, FSM states,
// PC-select codes and the latched instruction class.
package core_ctrl_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_FWAIT  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_MWAIT  = 3'd5,
    ST_WB     = 3'd6,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_e;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_BR      = 4'd3,
    CLS_I       = 4'd4,
    CLS_JALR    = 4'd5,
    CLS_JAL     = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_ILLEGAL = 4'd8
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OP_R:     return CLS_R;
      OP_LOAD:  return CLS_LOAD;
      OP_STORE: return CLS_STORE;
      OP_BR:    return CLS_BR;
      OP_I:     return CLS_I;
      OP_JALR:  return CLS_JALR;
      OP_JAL:   return CLS_JAL;
      OP_LUI:   return CLS_LUI;
      default:  return CLS_ILLEGAL;
    endcase
  endfunction

  // States that wait on an external memory handshake and are watchdog-guarded.
  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_FWAIT) || (s == ST_MEM) || (s == ST_MWAIT);
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-state cycle counter; flags the cycle in which the count reaches MEM_TIMEOUT.
module seq_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count_r;

  // Count cycles spent in a guarded state; saturate at the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the RV32I core,
// driving imem/dmem req-gnt-rvalid handshakes and one-cycle PC/IR/RF enables.
module multicycle_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       stall_i,
  output logic       imem_req_o,
  input  logic       imem_gnt_i,
  input  logic       imem_rvalid_i,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  input  logic       dmem_gnt_i,
  input  logic       dmem_rvalid_i,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       regwrite_o,
  output logic       memtoreg_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic       timeout_o,
  output logic [2:0] state_o
);

  state_e       state_r, state_next_s;
  instr_class_e class_r;
  pc_sel_e      pc_sel_s;
  logic         live_r, illegal_r, timeout_r;
  logic         set_illegal_s, set_timeout_s, expired_s;

  seq_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .clear   (!live_r || (state_next_s != state_r)),
    .enable  (is_mem_state(state_r)),
    .expired (expired_s)
  );

  // State, latched instruction class and sticky trap flags.
  // live_r keeps the FSM idle (and imem_req_o low) until the first edge after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_FETCH;
      class_r   <= CLS_R;
      live_r    <= 1'b0;
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      class_r   <= (state_r == ST_DECODE) ? classify(opcode_i) : class_r;
      live_r    <= 1'b1;
      illegal_r <= illegal_r | set_illegal_s;
      timeout_r <= timeout_r | set_timeout_s;
    end
  end

  // Next-state selection; a handshake in the expiry cycle takes priority over the trap.
  always_comb begin
    state_next_s  = state_r;
    set_illegal_s = 1'b0;
    set_timeout_s = 1'b0;
    if (!live_r) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (imem_gnt_i) state_next_s = ST_FWAIT;
          else if (expired_s) begin state_next_s = ST_TRAP; set_timeout_s = 1'b1; end
          else state_next_s = state_r;
        end
        ST_FWAIT: begin
          if (imem_rvalid_i) state_next_s = ST_DECODE;
          else if (expired_s) begin state_next_s = ST_TRAP; set_timeout_s = 1'b1; end
          else state_next_s = state_r;
        end
        ST_DECODE: begin
          if (stall_i) state_next_s = state_r;
          else if (classify(opcode_i) == CLS_ILLEGAL) begin
            state_next_s  = ST_TRAP;
            set_illegal_s = 1'b1;
          end else state_next_s = ST_EXEC;
        end
        ST_EXEC: begin
          if (stall_i) state_next_s = state_r;
          else if ((class_r == CLS_LOAD) || (class_r == CLS_STORE)) state_next_s = ST_MEM;
          else if (class_r == CLS_BR) state_next_s = ST_FETCH;
          else state_next_s = ST_WB;
        end
        ST_MEM: begin
          if (dmem_gnt_i) state_next_s = ST_MWAIT;
          else if (expired_s) begin state_next_s = ST_TRAP; set_timeout_s = 1'b1; end
          else state_next_s = state_r;
        end
        ST_MWAIT: begin
          if (dmem_rvalid_i) state_next_s = (class_r == CLS_STORE) ? ST_FETCH : ST_WB;
          else if (expired_s) begin state_next_s = ST_TRAP; set_timeout_s = 1'b1; end
          else state_next_s = state_r;
        end
        ST_WB: begin
          if (stall_i) state_next_s = state_r;
          else state_next_s = ST_FETCH;
        end
        ST_TRAP: state_next_s = ST_TRAP;
        default: state_next_s = ST_TRAP;
      endcase
    end
  end

  // Output decode from the registered state; only ir_we_o and the store-completion
  // pulses look at rvalid combinationally.
  always_comb begin
    imem_req_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_s   = PC_PLUS4;
    regwrite_o = 1'b0;
    memtoreg_o = 1'b0;
    retire_o   = 1'b0;
    case (state_r)
      ST_FETCH: imem_req_o = live_r;
      ST_FWAIT: ir_we_o = imem_rvalid_i;
      ST_DECODE: ir_we_o = 1'b0;
      ST_EXEC: begin
        if (!stall_i && (class_r == CLS_BR)) begin
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
          pc_sel_s = branch_taken_i ? PC_BRANCH : PC_PLUS4;
        end else begin
          pc_we_o = 1'b0;
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (class_r == CLS_STORE);
      end
      ST_MWAIT: begin
        if (dmem_rvalid_i && (class_r == CLS_STORE)) begin
          pc_we_o  = 1'b1;
          retire_o = 1'b1;
        end else begin
          pc_we_o = 1'b0;
        end
      end
      ST_WB: begin
        memtoreg_o = (class_r == CLS_LOAD);
        if (class_r == CLS_JAL) pc_sel_s = PC_JAL;
        else if (class_r == CLS_JALR) pc_sel_s = PC_JALR;
        else pc_sel_s = PC_PLUS4;
        if (!stall_i) begin
          regwrite_o = 1'b1;
          pc_we_o    = 1'b1;
          retire_o   = 1'b1;
        end else begin
          regwrite_o = 1'b0;
        end
      end
      ST_TRAP: imem_req_o = 1'b0;
      default: imem_req_o = 1'b0;
    endcase
  end

  assign pc_sel_o  = pc_sel_s;
  assign illegal_o = illegal_r;
  assign timeout_o = timeout_r;
  assign state_o   = state_r;

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Directed self-checking bench for multicycle_seq_ctrl (MEM_TIMEOUT=4).
module tb_multicycle_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [6:0] opcode_i = 7'd0;
  logic       branch_taken_i = 1'b0;
  logic       stall_i = 1'b0;
  logic       imem_req_o;
  logic       imem_gnt_i = 1'b0;
  logic       imem_rvalid_i = 1'b0;
  logic       dmem_req_o;
  logic       dmem_we_o;
  logic       dmem_gnt_i = 1'b0;
  logic       dmem_rvalid_i = 1'b0;
  logic       ir_we_o;
  logic       pc_we_o;
  logic [1:0] pc_sel_o;
  logic       regwrite_o;
  logic       memtoreg_o;
  logic       retire_o;
  logic       illegal_o;
  logic       timeout_o;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  multicycle_seq_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i),
    .branch_taken_i(branch_taken_i), .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
    .pc_sel_o(pc_sel_o), .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o),
    .retire_o(retire_o), .illegal_o(illegal_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  // From the start of a FETCH cycle: zero-wait fetch, ends in the DECODE cycle.
  task automatic fetch(input logic [6:0] op);
    imem_gnt_i = 1'b1; #1;
    chk("fetch_state", state_o, 8'd0);
    chk("fetch_req", imem_req_o, 8'd1);
    cyc(); imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; #1;
    chk("fwait_state", state_o, 8'd1);
    chk("fwait_ir_we", ir_we_o, 8'd1);
    chk("fwait_req", imem_req_o, 8'd0);
    cyc(); imem_rvalid_i = 1'b0; opcode_i = op; #1;
    chk("decode_state", state_o, 8'd2);
    chk("decode_ir_we", ir_we_o, 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_state", state_o, 8'd0);
    chk("rst_imem_req", imem_req_o, 8'd0);
    chk("rst_illegal", illegal_o, 8'd0);
    chk("rst_timeout", timeout_o, 8'd0);
    #4 rst_ni = 1'b1;
    cyc();

    // ADD: states 0,1,2,3,6,0
    fetch(7'b0110011);
    cyc(); #1;
    chk("add_exec_state", state_o, 8'd3);
    chk("add_exec_regwrite", regwrite_o, 8'd0);
    cyc(); #1;
    chk("add_wb_state", state_o, 8'd6);
    chk("add_wb_regwrite", regwrite_o, 8'd1);
    chk("add_wb_retire", retire_o, 8'd1);
    chk("add_wb_pc_we", pc_we_o, 8'd1);
    chk("add_wb_pc_sel", pc_sel_o, 8'd0);
    chk("add_wb_memtoreg", memtoreg_o, 8'd0);
    cyc(); #1;
    chk("add_back_fetch", state_o, 8'd0);
    chk("add_retire_low", retire_o, 8'd0);

    // LOAD: dmem gnt after 2 cycles, rvalid one cycle later
    fetch(7'b0000011);
    cyc(); #1;
    chk("ld_exec_state", state_o, 8'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(); dmem_gnt_i = (i == 2); #1;
      chk("ld_mem_state", state_o, 8'd4);
      chk("ld_mem_req", dmem_req_o, 8'd1);
      chk("ld_mem_we", dmem_we_o, 8'd0);
    end
    cyc(); dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; #1;
    chk("ld_mwait_state", state_o, 8'd5);
    chk("ld_mwait_req", dmem_req_o, 8'd0);
    chk("ld_mwait_retire", retire_o, 8'd0);
    cyc(); dmem_rvalid_i = 1'b0; #1;
    chk("ld_wb_state", state_o, 8'd6);
    chk("ld_wb_regwrite", regwrite_o, 8'd1);
    chk("ld_wb_memtoreg", memtoreg_o, 8'd1);
    chk("ld_wb_retire", retire_o, 8'd1);
    cyc(); #1;
    chk("ld_back_fetch", state_o, 8'd0);

    // STORE: retire on rvalid in MWAIT, no WB
    fetch(7'b0100011);
    cyc(); cyc(); dmem_gnt_i = 1'b1; #1;
    chk("st_mem_state", state_o, 8'd4);
    chk("st_mem_we", dmem_we_o, 8'd1);
    cyc(); dmem_gnt_i = 1'b0; #1;
    chk("st_mwait_noval_pc_we", pc_we_o, 8'd0);
    dmem_rvalid_i = 1'b1; #1;
    chk("st_mwait_pc_we", pc_we_o, 8'd1);
    chk("st_mwait_retire", retire_o, 8'd1);
    chk("st_mwait_regwrite", regwrite_o, 8'd0);
    cyc(); dmem_rvalid_i = 1'b0; #1;
    chk("st_back_fetch", state_o, 8'd0);

    // BR taken, then BR not taken
    fetch(7'b1100011);
    cyc(); branch_taken_i = 1'b1; #1;
    chk("brt_exec_state", state_o, 8'd3);
    chk("brt_pc_we", pc_we_o, 8'd1);
    chk("brt_pc_sel", pc_sel_o, 8'd1);
    chk("brt_retire", retire_o, 8'd1);
    chk("brt_regwrite", regwrite_o, 8'd0);
    cyc(); branch_taken_i = 1'b0; #1;
    chk("brt_back_fetch", state_o, 8'd0);
    fetch(7'b1100011);
    cyc(); #1;
    chk("brn_pc_we", pc_we_o, 8'd1);
    chk("brn_pc_sel", pc_sel_o, 8'd0);
    cyc();

    // JAL with 3-cycle stall in WB
    fetch(7'b1101111);
    cyc(); cyc(); stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("jal_stall_state", state_o, 8'd6);
      chk("jal_stall_regwrite", regwrite_o, 8'd0);
      chk("jal_stall_pc_we", pc_we_o, 8'd0);
      chk("jal_stall_retire", retire_o, 8'd0);
      cyc();
    end
    stall_i = 1'b0; #1;
    chk("jal_rel_state", state_o, 8'd6);
    chk("jal_rel_regwrite", regwrite_o, 8'd1);
    chk("jal_rel_pc_we", pc_we_o, 8'd1);
    chk("jal_rel_pc_sel", pc_sel_o, 8'd2);
    cyc(); #1;
    chk("jal_back_fetch", state_o, 8'd0);
    chk("jal_single_pulse", regwrite_o, 8'd0);

    // JALR with a stall in DECODE
    fetch(7'b1100111);
    stall_i = 1'b1;
    cyc(); #1;
    chk("jalr_decode_hold", state_o, 8'd2);
    stall_i = 1'b0;
    cyc(); cyc(); #1;
    chk("jalr_wb_state", state_o, 8'd6);
    chk("jalr_pc_sel", pc_sel_o, 8'd3);
    cyc(); #1;

    // Fetch watchdog: no grant for 4 cycles -> TRAP
    for (int i = 0; i < 4; i++) begin
      chk("wd_fetch_state", state_o, 8'd0);
      chk("wd_fetch_req", imem_req_o, 8'd1);
      cyc(); #1;
    end
    chk("wd_trap_state", state_o, 8'd7);
    chk("wd_timeout", timeout_o, 8'd1);
    chk("wd_illegal", illegal_o, 8'd0);
    chk("wd_trap_req", imem_req_o, 8'd0);

    // Reset out of TRAP, then reset mid-FWAIT with a late rvalid
    rst_ni = 1'b0; #1;
    chk("rst2_state", state_o, 8'd0);
    chk("rst2_timeout", timeout_o, 8'd0);
    rst_ni = 1'b1;
    cyc(); imem_gnt_i = 1'b1; #1;
    chk("rst2_req", imem_req_o, 8'd1);
    cyc(); imem_gnt_i = 1'b0; #1;
    chk("rst3_fwait", state_o, 8'd1);
    rst_ni = 1'b0; #1;
    chk("rst3_state", state_o, 8'd0);
    chk("rst3_req", imem_req_o, 8'd0);
    rst_ni = 1'b1;
    cyc(); imem_rvalid_i = 1'b1; #1;
    chk("late_rvalid_ir_we", ir_we_o, 8'd0);
    chk("late_rvalid_state", state_o, 8'd0);
    cyc(); imem_rvalid_i = 1'b0; #1;
    chk("late_rvalid_ignored", state_o, 8'd0);

    // Illegal opcode -> absorbing TRAP
    fetch(7'b1111111);
    cyc(); #1;
    chk("ill_trap_state", state_o, 8'd7);
    chk("ill_illegal", illegal_o, 8'd1);
    chk("ill_timeout", timeout_o, 8'd0);
    imem_gnt_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      chk("ill_trap_req", imem_req_o, 8'd0);
      chk("ill_trap_hold", state_o, 8'd7);
    end
    imem_gnt_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
